// File: rtl/apb_master.sv
// APB initiator: turns a valid/ready command into one APB SETUP/ACCESS
// transfer and returns read data plus error/timeout status on a
// valid/ready response channel. One transfer is in flight at a time.
//
// state  | meaning
// -------+----------------------------------------------------------
// IDLE   | waiting for a command; cmd_ready is high
// SETUP  | psel=1, penable=0 for exactly one cycle
// ACCESS | psel=1, penable=1; waiting for pready or the timeout
// RESP   | response presented until the consumer takes it
module apb_master #(
  parameter int APB_ADDR_WIDTH = 16,
  parameter int APB_DATA_WIDTH = 16,
  parameter int TIMEOUT_CYCLES = 255,
  parameter int TO_WIDTH       = 8
) (
  input  logic                      pclk,
  input  logic                      preset,
  input  logic                      i_cmd_valid,
  output logic                      o_cmd_ready,
  input  logic                      i_cmd_write,
  input  logic [APB_ADDR_WIDTH-1:0] i_cmd_addr,
  input  logic [APB_DATA_WIDTH-1:0] i_cmd_wdata,
  output logic                      o_rsp_valid,
  input  logic                      i_rsp_ready,
  output logic [APB_DATA_WIDTH-1:0] o_rsp_rdata,
  output logic                      o_rsp_err,
  output logic                      o_rsp_timeout,
  output logic                      o_psel,
  output logic                      o_penable,
  output logic                      o_pwrite,
  output logic [APB_ADDR_WIDTH-1:0] o_paddr,
  output logic [APB_DATA_WIDTH-1:0] o_pwdata,
  input  logic                      i_pready,
  input  logic [APB_DATA_WIDTH-1:0] i_prdata,
  input  logic                      i_pslverr
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2,
    ST_RESP   = 2'd3
  } state_t;

  // Last wait-counter value before the abort fires; meaningless when the
  // timeout is disabled, which TO_EN masks out.
  localparam logic [TO_WIDTH-1:0] TO_LAST = TO_WIDTH'(TIMEOUT_CYCLES - 1);
  localparam bit                  TO_EN   = (TIMEOUT_CYCLES != 0);

  state_t              state;
  logic [TO_WIDTH-1:0] wait_cnt;
  logic                timeout_hit;

  // Abort condition; pready takes priority over this in ACCESS.
  assign timeout_hit = TO_EN && (wait_cnt == TO_LAST);

  // Commands are only taken while idle.
  assign o_cmd_ready = (state == ST_IDLE);

  // Transfer sequencer with all APB and response outputs registered.
  always_ff @(posedge pclk) begin
    if (preset) begin
      state         <= ST_IDLE;
      wait_cnt      <= '0;
      o_psel        <= 1'b0;
      o_penable     <= 1'b0;
      o_pwrite      <= 1'b0;
      o_paddr       <= '0;
      o_pwdata      <= '0;
      o_rsp_valid   <= 1'b0;
      o_rsp_rdata   <= '0;
      o_rsp_err     <= 1'b0;
      o_rsp_timeout <= 1'b0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (i_cmd_valid) begin
            o_pwrite  <= i_cmd_write;
            o_paddr   <= i_cmd_addr;
            // Reads drive zero write data so the bus does not leak stale data.
            o_pwdata  <= i_cmd_write ? i_cmd_wdata : '0;
            o_psel    <= 1'b1;
            o_penable <= 1'b0;
            state     <= ST_SETUP;
          end
        end

        ST_SETUP: begin
          o_penable <= 1'b1;
          state     <= ST_ACCESS;
        end

        ST_ACCESS: begin
          if (i_pready) begin
            o_psel        <= 1'b0;
            o_penable     <= 1'b0;
            o_rsp_valid   <= 1'b1;
            o_rsp_err     <= i_pslverr;
            o_rsp_timeout <= 1'b0;
            o_rsp_rdata   <= (!o_pwrite && !i_pslverr) ? i_prdata : '0;
            state         <= ST_RESP;
          end else begin
            // Saturating increment: only reachable with the timeout disabled.
            if (wait_cnt != '1) begin
              wait_cnt <= wait_cnt + TO_WIDTH'(1);
            end
            if (timeout_hit) begin
              o_psel        <= 1'b0;
              o_penable     <= 1'b0;
              o_rsp_valid   <= 1'b1;
              o_rsp_err     <= 1'b1;
              o_rsp_timeout <= 1'b1;
              o_rsp_rdata   <= '0;
              state         <= ST_RESP;
            end
          end
        end

        ST_RESP: begin
          if (i_rsp_ready) begin
            o_rsp_valid <= 1'b0;
            wait_cnt    <= '0;
            state       <= ST_IDLE;
          end
        end

        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_apb_master.sv
// Randomized bench for apb_master: each transfer's responder behaviour
// (wait states, slave error, read data) is chosen up front and the expected
// latency, penable length and response are computed from the transfer rules.
module tb_apb_master;

  localparam int AW = 16;
  localparam int DW = 16;
  localparam int TO = 8;

  logic          pclk;
  logic          preset;
  logic          i_cmd_valid;
  logic          o_cmd_ready;
  logic          i_cmd_write;
  logic [AW-1:0] i_cmd_addr;
  logic [DW-1:0] i_cmd_wdata;
  logic          o_rsp_valid;
  logic          i_rsp_ready;
  logic [DW-1:0] o_rsp_rdata;
  logic          o_rsp_err;
  logic          o_rsp_timeout;
  logic          o_psel;
  logic          o_penable;
  logic          o_pwrite;
  logic [AW-1:0] o_paddr;
  logic [DW-1:0] o_pwdata;
  logic          i_pready;
  logic [DW-1:0] i_prdata;
  logic          i_pslverr;

  int checks = 0;
  int errors = 0;

  apb_master #(
    .APB_ADDR_WIDTH(AW),
    .APB_DATA_WIDTH(DW),
    .TIMEOUT_CYCLES(TO),
    .TO_WIDTH(8)
  ) dut (
    .pclk(pclk),
    .preset(preset),
    .i_cmd_valid(i_cmd_valid),
    .o_cmd_ready(o_cmd_ready),
    .i_cmd_write(i_cmd_write),
    .i_cmd_addr(i_cmd_addr),
    .i_cmd_wdata(i_cmd_wdata),
    .o_rsp_valid(o_rsp_valid),
    .i_rsp_ready(i_rsp_ready),
    .o_rsp_rdata(o_rsp_rdata),
    .o_rsp_err(o_rsp_err),
    .o_rsp_timeout(o_rsp_timeout),
    .o_psel(o_psel),
    .o_penable(o_penable),
    .o_pwrite(o_pwrite),
    .o_paddr(o_paddr),
    .o_pwdata(o_pwdata),
    .i_pready(i_pready),
    .i_prdata(i_prdata),
    .i_pslverr(i_pslverr)
  );

  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  initial begin
    #400000;
    $display("FAIL watchdog obs=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  // One full transfer. waits >= TO means the responder never answers.
  // hold = cycles rsp_ready stays low after rsp_valid rises.
  task automatic run_txn(input bit wr, input logic [AW-1:0] addr,
                         input logic [DW-1:0] wd, input int waits,
                         input bit slv, input logic [DW-1:0] rd, input int hold);
    int            cyc, first_psel, first_pen, pen_cnt, lat;
    bit            to;
    int            exp_lat, exp_pen;
    logic [DW-1:0] exp_pwdata, exp_rdata;
    bit            exp_err;

    to         = (waits >= TO);
    exp_lat    = to ? 2 + TO : 3 + waits;
    exp_pen    = to ? TO : waits + 1;
    exp_err    = to || slv;
    exp_rdata  = (!wr && !to && !slv) ? rd : '0;
    exp_pwdata = wr ? wd : '0;

    @(negedge pclk);
    chk("cmd_ready_idle", o_cmd_ready, 1);
    i_cmd_valid = 1'b1;
    i_cmd_write = wr;
    i_cmd_addr  = addr;
    i_cmd_wdata = wd;
    i_rsp_ready = 1'b0;
    i_pready    = 1'($urandom);
    i_prdata    = DW'($urandom);
    i_pslverr   = 1'($urandom);
    @(posedge pclk);

    cyc = 0; first_psel = -1; first_pen = -1; pen_cnt = 0; lat = -1;
    while (lat < 0 && cyc < 60) begin
      @(negedge pclk);
      cyc++;
      // Junk commands while busy must be ignored.
      i_cmd_write = 1'($urandom);
      i_cmd_addr  = AW'($urandom);
      i_cmd_wdata = DW'($urandom);
      i_prdata    = DW'($urandom);
      i_pslverr   = 1'($urandom);
      if (o_rsp_valid) begin
        lat      = cyc;
        i_pready = 1'($urandom);
      end else begin
        if (o_psel && first_psel < 0) first_psel = cyc;
        if (o_penable) begin
          if (first_pen < 0) first_pen = cyc;
          pen_cnt++;
        end
        if (o_psel) begin
          chk("paddr_stable", o_paddr, addr);
          chk("pwrite_stable", o_pwrite, wr);
          chk("pwdata_stable", o_pwdata, exp_pwdata);
        end
        if (o_penable && pen_cnt == waits + 1) begin
          i_pready  = 1'b1;
          i_prdata  = rd;
          i_pslverr = slv;
        end else if (o_penable) begin
          i_pready = 1'b0;
        end else begin
          i_pready = 1'($urandom);
        end
      end
    end

    chk("rsp_latency", lat, exp_lat);
    if (lat < 0) return;
    chk("first_psel_cycle", first_psel, 1);
    chk("first_penable_cycle", first_pen, 2);
    chk("penable_cycles", pen_cnt, exp_pen);
    chk("psel_low_in_resp", {o_psel, o_penable}, 2'b00);
    chk("rsp_rdata", o_rsp_rdata, exp_rdata);
    chk("rsp_err", o_rsp_err, exp_err);
    chk("rsp_timeout", o_rsp_timeout, to);

    for (int h = 0; h < hold; h++) begin
      @(negedge pclk);
      i_pready = 1'($urandom);
      chk("hold_rsp_valid", o_rsp_valid, 1);
      chk("hold_rsp_data", {o_rsp_rdata, o_rsp_err, o_rsp_timeout}, {exp_rdata, exp_err, to});
      chk("hold_cmd_ready", o_cmd_ready, 0);
      chk("hold_no_psel", o_psel, 0);
    end
    i_rsp_ready = 1'b1;
    @(posedge pclk);
  endtask

  task automatic reset_mid_access();
    @(negedge pclk);
    i_cmd_valid = 1'b1;
    i_cmd_write = 1'b0;
    i_cmd_addr  = 16'h0123;
    i_rsp_ready = 1'b0;
    i_pready    = 1'b0;
    @(posedge pclk);
    @(negedge pclk);
    i_cmd_valid = 1'b0;
    @(negedge pclk);
    chk("rst_mid_in_access", o_penable, 1);
    preset = 1'b1;
    @(negedge pclk);
    preset = 1'b0;
    chk("rst_mid_psel_penable", {o_psel, o_penable}, 2'b00);
    chk("rst_mid_cmd_ready", o_cmd_ready, 1);
    chk("rst_mid_rsp_valid", o_rsp_valid, 0);
    @(negedge pclk);
    chk("rst_mid_no_rsp_later", o_rsp_valid, 0);
  endtask

  initial begin
    preset      = 1'b1;
    i_cmd_valid = 1'b0;
    i_cmd_write = 1'b0;
    i_cmd_addr  = '0;
    i_cmd_wdata = '0;
    i_rsp_ready = 1'b0;
    i_pready    = 1'b0;
    i_prdata    = '0;
    i_pslverr   = 1'b0;
    repeat (3) @(negedge pclk);
    chk("rst_cmd_ready", o_cmd_ready, 1);
    chk("rst_apb_ctl", {o_psel, o_penable, o_pwrite}, 3'b000);
    chk("rst_rsp_flags", {o_rsp_valid, o_rsp_err, o_rsp_timeout}, 3'b000);
    chk("rst_paddr", o_paddr, 0);
    chk("rst_pwdata", o_pwdata, 0);
    chk("rst_rdata", o_rsp_rdata, 0);
    preset = 1'b0;

    run_txn(1'b1, 16'h0010, 16'hA5A5, 0, 1'b0, 16'h1234, 0);
    run_txn(1'b0, 16'h0004, 16'h5555, 3, 1'b0, 16'h00C3, 0);
    run_txn(1'b0, 16'h0020, 16'h0000, 1000, 1'b0, 16'h7777, 0);
    run_txn(1'b0, 16'h0030, 16'h0000, 0, 1'b1, 16'hFFFF, 0);
    run_txn(1'b1, 16'h0040, 16'h3C3C, TO - 1, 1'b0, 16'h0000, 0);
    run_txn(1'b0, 16'h0050, 16'h0000, 1, 1'b0, 16'hBEEF, 5);
    run_txn(1'b1, 16'h0060, 16'h0F0F, 0, 1'b0, 16'h0000, 0);
    reset_mid_access();
    run_txn(1'b0, 16'h0070, 16'h0000, 2, 1'b0, 16'h4242, 1);

    for (int n = 0; n < 40; n++) begin
      run_txn(1'($urandom), AW'($urandom), DW'($urandom),
              int'($urandom_range(0, 10)), ($urandom_range(0, 3) == 0),
              DW'($urandom), int'($urandom_range(0, 3)));
    end

    @(negedge pclk);
    i_cmd_valid = 1'b0;
    i_rsp_ready = 1'b0;
    repeat (2) @(negedge pclk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
